// File: rtl/mem_arb.sv
// mem_arb: N-channel memory-access arbiter that routes each access to SRAM or the IO bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, channel 0 highest.
module mem_arb #(
    parameter int NCH     = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SRAM_AW = 16,
    parameter int TMO_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        i_req_val,
    output logic [NCH-1:0]        o_req_rdy,
    input  logic [NCH*AW-1:0]     i_req_adr,
    input  logic [NCH*DW-1:0]     i_req_wdat,
    input  logic [NCH*DW/8-1:0]   i_req_wen,
    output logic [DW-1:0]         o_rdat,
    output logic                  o_err,
    output logic [2:0]            o_rsp_id,
    output logic [AW-1:0]         o_adr,
    output logic [DW-1:0]         o_wdat,
    output logic                  o_sram_val,
    output logic [DW/8-1:0]       o_sram_wen,
    input  logic [DW-1:0]         i_sram_rdat,
    output logic                  o_iob_val,
    output logic [DW/8-1:0]       o_iob_wen,
    input  logic                  i_iob_rdy,
    input  logic [DW-1:0]         i_iob_rdat
);
    localparam int WW = DW / 8;

    // state    | meaning
    // IDLE     | nothing outstanding, issue allowed
    // SRAM_RSP | SRAM access completes this cycle, issue allowed
    // IOB_WAIT | IO-bus access outstanding, waiting for ready or timeout
    typedef enum logic [1:0] {IDLE, SRAM_RSP, IOB_WAIT} state_t;

    state_t      state;
    logic [2:0]  gnt_q;
    logic        sram_q;
    logic [15:0] cnt_q;
`ifdef MEM_ARB_RR_EN
    logic [2:0]  ptr_q;
`endif

    logic [NCH-1:0] cmpl_mask;
    logic [NCH-1:0] cand;
    logic           issue;
    logic [2:0]     win;
    logic [2:0]     sel;
    int             idx;
    logic [AW-1:0]  sel_adr;
    logic [DW-1:0]  sel_wdat;
    logic [WW-1:0]  sel_wen;
    logic           win_sram;
    logic           tmo_hit;
    logic           iob_done;

    // The channel completing now still holds its request; keep it out of this issue.
    assign cmpl_mask = (state == SRAM_RSP) ? (NCH'(1) << gnt_q) : '0;
    assign cand      = (state != IOB_WAIT) ? (i_req_val & ~cmpl_mask) : '0;

    always_comb begin
        issue = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
`ifdef MEM_ARB_RR_EN
            idx = (int'(ptr_q) + 1 + i) % NCH;
`else
            idx = i;
`endif
            if (!issue && ((cand & (NCH'(1) << idx)) != '0)) begin
                issue = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    assign sel      = (state == IOB_WAIT) ? gnt_q : win;
    assign sel_adr  = AW'(i_req_adr >> (int'(sel) * AW));
    assign sel_wdat = DW'(i_req_wdat >> (int'(sel) * DW));
    assign sel_wen  = WW'(i_req_wen >> (int'(sel) * WW));
    assign win_sram = ((sel_adr >> SRAM_AW) == '0);

    // cnt_q counts completed wait cycles, so the timeout lands exactly TMO_CYC cycles after issue.
    assign tmo_hit  = (TMO_CYC != 0) && (({1'b0, cnt_q} + 17'd1) == 17'(TMO_CYC));
    assign iob_done = (state == IOB_WAIT) && (i_iob_rdy || tmo_hit);

    always_comb begin
        o_req_rdy  = '0;
        o_rdat     = '0;
        o_err      = 1'b0;
        o_rsp_id   = '0;
        o_adr      = '0;
        o_wdat     = '0;
        o_sram_val = 1'b0;
        o_sram_wen = '0;
        o_iob_val  = 1'b0;
        o_iob_wen  = '0;
        if (!rst) begin
            if (issue || state == IOB_WAIT) begin
                o_adr  = sel_adr;
                o_wdat = sel_wdat;
            end
            if (issue && win_sram) begin
                o_sram_val = 1'b1;
                o_sram_wen = sel_wen;
            end
            if (issue && !win_sram) begin
                o_iob_val = 1'b1;
                o_iob_wen = sel_wen;
            end
            if (state == IOB_WAIT && !sram_q) begin
                o_iob_wen = sel_wen;
            end
            if (state == SRAM_RSP) begin
                o_req_rdy = NCH'(1) << gnt_q;
                o_rsp_id  = gnt_q;
                o_rdat    = i_sram_rdat;
            end else if (iob_done) begin
                o_req_rdy = NCH'(1) << gnt_q;
                o_rsp_id  = gnt_q;
                if (i_iob_rdy) begin
                    o_rdat = i_iob_rdat;
                end else begin
                    o_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            gnt_q  <= '0;
            sram_q <= 1'b0;
            cnt_q  <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q  <= '0;
`endif
        end else if (issue) begin
            state  <= win_sram ? SRAM_RSP : IOB_WAIT;
            gnt_q  <= win;
            sram_q <= win_sram;
            cnt_q  <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q  <= win;
`endif
        end else if (state == IOB_WAIT && !iob_done) begin
            cnt_q <= cnt_q + 16'd1;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb (NCH=3, TMO_CYC=4); honours MEM_ARB_RR_EN if defined.
module tb_mem_arb;
    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int WW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    i_req_val;
    logic [NCH-1:0]    o_req_rdy;
    logic [NCH*AW-1:0] i_req_adr;
    logic [NCH*DW-1:0] i_req_wdat;
    logic [NCH*WW-1:0] i_req_wen;
    logic [DW-1:0]     o_rdat;
    logic              o_err;
    logic [2:0]        o_rsp_id;
    logic [AW-1:0]     o_adr;
    logic [DW-1:0]     o_wdat;
    logic              o_sram_val;
    logic [WW-1:0]     o_sram_wen;
    logic [DW-1:0]     i_sram_rdat;
    logic              o_iob_val;
    logic [WW-1:0]     o_iob_wen;
    logic              i_iob_rdy;
    logic [DW-1:0]     i_iob_rdat;

    mem_arb #(.NCH(NCH), .AW(AW), .DW(DW), .SRAM_AW(16), .TMO_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .i_req_val(i_req_val), .o_req_rdy(o_req_rdy),
        .i_req_adr(i_req_adr), .i_req_wdat(i_req_wdat), .i_req_wen(i_req_wen),
        .o_rdat(o_rdat), .o_err(o_err), .o_rsp_id(o_rsp_id),
        .o_adr(o_adr), .o_wdat(o_wdat),
        .o_sram_val(o_sram_val), .o_sram_wen(o_sram_wen), .i_sram_rdat(i_sram_rdat),
        .o_iob_val(o_iob_val), .o_iob_wen(o_iob_wen),
        .i_iob_rdy(i_iob_rdy), .i_iob_rdat(i_iob_rdat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] rdat;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] adr[NCH];
    logic [31:0] wdat[NCH];
    logic [3:0]  wen[NCH];
    int          cnt_left[NCH];
    logic [2:0]  rdy_last;
    int          ord[6];
    int          ncyc;

    function automatic logic [31:0] sram_data(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Each requester holds its request until it has seen cnt_left completions.
    always_comb begin
        i_req_val  = '0;
        i_req_adr  = '0;
        i_req_wdat = '0;
        i_req_wen  = '0;
        for (int c = 0; c < NCH; c++) begin
            i_req_val[c]          = (cnt_left[c] != 0);
            i_req_adr[c*AW +: AW] = adr[c];
            i_req_wdat[c*DW +: DW] = wdat[c];
            i_req_wen[c*WW +: WW] = wen[c];
        end
    end

    always @(posedge clk) begin
        i_sram_rdat <= o_sram_val ? sram_data(o_adr) : 32'hDEAD_BEEF;
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] rdat, input logic err);
        exp_t e;
        e.id   = 3'(id);
        e.rdat = rdat;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (o_req_rdy != '0) begin
            if (sb.size() == 0) begin
                check_val("unexp_rdy", o_req_rdy, 0);
            end else begin
                e = sb.pop_front();
                check_val("rdy_vec", o_req_rdy, 3'b001 << e.id);
                check_val("rsp_id", o_rsp_id, e.id);
                check_val("rdat", o_rdat, e.rdat);
                check_val("err", o_err, e.err);
            end
        end else begin
            check_val("idle_rdat", o_rdat, 0);
            check_val("idle_rsp_id", o_rsp_id, 0);
        end
        rdy_last = o_req_rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (rdy_last[c] && cnt_left[c] != 0) cnt_left[c]--;
        end
        rdy_last = '0;
    endtask

    task automatic cyc();
        sample();
        tick();
    endtask

    task automatic drain(input string tag, input int budget, output int n);
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        check_val(tag, sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        i_iob_rdy  = 1'b0;
        i_iob_rdat = 32'hBAD0_0001;
        rdy_last   = '0;
        for (int c = 0; c < NCH; c++) begin
            adr[c] = '0; wdat[c] = '0; wen[c] = '0; cnt_left[c] = 0;
        end

        // Reset: outputs quiet even with a request pending
        adr[0] = 32'h40; wdat[0] = 32'h1111_2222; cnt_left[0] = 1;
        tick();
        sample();
        check_val("rst_sram_val", o_sram_val, 0);
        check_val("rst_iob_val", o_iob_val, 0);
        check_val("rst_adr", o_adr, 0);
        check_val("rst_wdat", o_wdat, 0);
        check_val("rst_rdy", o_req_rdy, 0);
        tick();
        rst = 1'b0; cnt_left[0] = 0; wdat[0] = '0;
        cyc();

        // ch1 single SRAM read
        adr[1] = 32'h0000_0040; cnt_left[1] = 1;
        push_exp(1, sram_data(32'h40), 1'b0);
        sample();
        check_val("t1_sram_val", o_sram_val, 1);
        check_val("t1_iob_val", o_iob_val, 0);
        check_val("t1_adr", o_adr, 32'h40);
        check_val("t1_rdy_early", o_req_rdy, 0);
        tick();
        sample();
        check_val("t1_rdy", o_req_rdy, 3'b010);
        check_val("t1_no_reissue", o_sram_val, 0);
        tick();
        cyc();

        // ch0 and ch2 stream SRAM reads
        adr[0] = 32'h100; adr[2] = 32'h200; cnt_left[0] = 3; cnt_left[2] = 3;
`ifdef MEM_ARB_RR_EN
        ord = '{2, 0, 2, 0, 2, 0};
`else
        ord = '{0, 2, 0, 2, 0, 2};
`endif
        for (int k = 0; k < 6; k++) push_exp(ord[k], sram_data(adr[ord[k]]), 1'b0);
        drain("t2_drain", 20, ncyc);
        check_val("t2_thruput", ncyc, 7);
        cyc();

        // ch2 IO write, ready after 3 cycles; ch0 SRAM read must wait
        adr[2] = 32'h1000_0000; wen[2] = 4'hF; wdat[2] = 32'h1234_5678; cnt_left[2] = 1;
        i_iob_rdat = 32'hCAFE_0001;
        push_exp(2, 32'hCAFE_0001, 1'b0);
        sample();
        check_val("t3_iob_val", o_iob_val, 1);
        check_val("t3_iob_wen", o_iob_wen, 4'hF);
        check_val("t3_sram_wen", o_sram_wen, 0);
        check_val("t3_sram_val", o_sram_val, 0);
        check_val("t3_adr", o_adr, 32'h1000_0000);
        check_val("t3_wdat", o_wdat, 32'h1234_5678);
        tick();
        adr[0] = 32'h80; cnt_left[0] = 1;
        push_exp(0, sram_data(32'h80), 1'b0);
        sample();
        check_val("t3_hold_adr", o_adr, 32'h1000_0000);
        check_val("t3_hold_wen", o_iob_wen, 4'hF);
        check_val("t3_no_iob_val", o_iob_val, 0);
        check_val("t3_blk1", o_sram_val, 0);
        tick();
        sample();
        check_val("t3_blk2", o_sram_val, 0);
        tick();
        i_iob_rdy = 1'b1;
        sample();
        check_val("t3_rdy", o_req_rdy, 3'b100);
        check_val("t3_blk3", o_sram_val, 0);
        tick();
        i_iob_rdy = 1'b0; i_iob_rdat = 32'hBAD0_0002; wen[2] = '0; wdat[2] = '0;
        sample();
        check_val("t3_ch0_issue", o_sram_val, 1);
        check_val("t3_ch0_adr", o_adr, 32'h80);
        tick();
        drain("t3_drain", 10, ncyc);
        cyc();

        // ch1 IO read times out; same-cycle and late ready ignored
        adr[1] = 32'h0002_0000; cnt_left[1] = 1; i_iob_rdy = 1'b1;
        push_exp(1, 32'h0, 1'b1);
        sample();
        check_val("t4_iob_val", o_iob_val, 1);
        check_val("t4_rdy_ign", o_req_rdy, 0);
        tick();
        i_iob_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check_val("t4_wait", o_req_rdy, 0);
            tick();
        end
        sample();
        check_val("t4_tmo", o_req_rdy, 3'b010);
        check_val("t4_err", o_err, 1);
        tick();
        cyc();
        i_iob_rdy = 1'b1;
        sample();
        check_val("t4_late", o_req_rdy, 0);
        tick();
        i_iob_rdy = 1'b0;
        cyc();

        // Reset during IOB_WAIT abandons the access
        adr[0] = 32'h8000_0000; wdat[0] = 32'h5555_AAAA; cnt_left[0] = 1;
        sample();
        check_val("t6_iob_val", o_iob_val, 1);
        tick();
        cyc();
        rst = 1'b1; i_iob_rdy = 1'b1;
        sample();
        check_val("t6_rst_rdy", o_req_rdy, 0);
        check_val("t6_rst_iob_val", o_iob_val, 0);
        check_val("t6_rst_iob_wen", o_iob_wen, 0);
        check_val("t6_rst_adr", o_adr, 0);
        check_val("t6_rst_wdat", o_wdat, 0);
        check_val("t6_rst_err", o_err, 0);
        tick();
        rst = 1'b0; cnt_left[0] = 0; wdat[0] = '0;
        sample();
        check_val("t6_post_rdy", o_req_rdy, 0);
        tick();
        i_iob_rdy = 1'b0;

        // All three channels stream SRAM reads from a fresh reset
        adr[0] = 32'h300; adr[1] = 32'h310; adr[2] = 32'h320;
        cnt_left[0] = 2; cnt_left[1] = 2; cnt_left[2] = 2;
`ifdef MEM_ARB_RR_EN
        ord = '{1, 2, 0, 1, 2, 0};
`else
        ord = '{0, 1, 0, 1, 2, 2};
`endif
        for (int k = 0; k < 6; k++) push_exp(ord[k], sram_data(adr[ord[k]]), 1'b0);
        drain("t5_drain", 20, ncyc);
`ifdef MEM_ARB_RR_EN
        check_val("t5_cycles", ncyc, 7);
`else
        check_val("t5_cycles", ncyc, 8);
`endif
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
# mem_arb

Parametrised N-channel memory-access arbiter and target router for the core's load/store path. It selects one requester per issue slot and routes the access to SRAM or the IO bus by address decode. SRAM reads complete back-to-back at one access per cycle; IO-bus accesses wait for the bus ready under a timeout. It replaces the fixed three-requester LSU front end with a configurable channel count and arbitration policy.

## Interface
Parameters:
- NCH, 3, number of requester channels (1..8); channel 0 is highest priority in fixed mode
- AW, 32, address width
- DW, 32, data width (multiple of 8); write-enable width WW = DW/8
- SRAM_AW, 16, SRAM region is adr[AW-1:SRAM_AW] == 0; everything else goes to the IO bus
- TMO_CYC, 255, IO-bus timeout in cycles (1..65535); 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- i_req_val  in  NCH  per-channel request valid; held until o_req_rdy
- o_req_rdy  out  NCH  per-channel completion strobe, one-hot or zero
- i_req_adr  in  NCH*AW  channel c at [c*AW +: AW]
- i_req_wdat  in  NCH*DW  write data, packed the same way
- i_req_wen  in  NCH*WW  byte write enables; all-zero means read
- o_rdat  out  DW  read data, valid with o_req_rdy
- o_err  out  1  timeout flag, valid with o_req_rdy
- o_rsp_id  out  3  index of the channel being completed
- o_adr  out  AW  address to both targets
- o_wdat  out  DW  write data to both targets
- o_sram_val  out  1  SRAM access strobe
- o_sram_wen  out  WW  SRAM byte enables, masked by the region select
- i_sram_rdat  in  DW  SRAM read data, one cycle after the strobe
- o_iob_val  out  1  IO-bus access strobe
- o_iob_wen  out  WW  IO-bus byte enables, masked by the region select
- i_iob_rdy  in  1  IO-bus completion
- i_iob_rdat  in  DW  IO-bus read data, valid with i_iob_rdy

## Operation
- States: IDLE, SRAM_RSP, IOB_WAIT.
- Issue is allowed in IDLE and in SRAM_RSP. The candidate set is i_req_val, excluding the channel completing in this cycle.
  - The winner's adr, wdat and wen drive o_adr, o_wdat and the wen outputs combinationally.
  - Exactly one of o_sram_val or o_iob_val pulses for one cycle.
  - The grant index and the region select are registered.
- Next state after an issue: SRAM region -> SRAM_RSP; IO region -> IOB_WAIT. With no issue the block returns to IDLE.
- SRAM_RSP:
  - o_req_rdy[gnt] = 1, o_rdat = i_sram_rdat, o_err = 0.
  - A new issue may occur in the same cycle.
- IOB_WAIT:
  - No issue is allowed.
  - o_adr, o_wdat and o_iob_wen are held from the granted channel; o_iob_val = 0.
  - i_iob_rdy -> o_req_rdy[gnt] = 1, o_rdat = i_iob_rdat, then IDLE.
  - Timeout counter (16 bits) is cleared on issue and increments each IOB_WAIT cycle. When it equals TMO_CYC with no i_iob_rdy: o_req_rdy[gnt] = 1, o_err = 1, o_rdat = 0, then IDLE.
  - i_iob_rdy takes precedence over the timeout in the same cycle.
- i_iob_rdy outside IOB_WAIT is ignored, including a late response after a timeout.
- o_rdat = 0 and o_rsp_id = 0 whenever no o_req_rdy bit is set.
- Fixed priority: lowest active index wins.

## Timing
- Reset: state IDLE, grant 0, counter 0. All outputs are 0 while rst is high, including o_req_rdy, o_sram_val, o_iob_val, o_err, o_adr and o_wdat.
- rst asserted mid-transaction abandons the access; no o_req_rdy is issued afterwards.
- SRAM latency: issue in cycle N -> o_req_rdy in N+1. Sustained throughput is one access per cycle, alternating between channels when several compete.
- IO-bus latency: issue in cycle N. o_req_rdy arrives in the same cycle as i_iob_rdy, earliest N+1; i_iob_rdy in cycle N is ignored. The timeout response comes in cycle N+TMO_CYC.
- A requester must hold val and its payload stable until its o_req_rdy cycle. It may drop or re-raise val in the cycle after rdy.
- The completing channel is excluded from the same-cycle issue. This prevents a duplicate grant of the request it is still holding.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A registered last-grant pointer (reset 0) updates on each issue, and the search starts at pointer+1 modulo NCH.
- MEM_ARB_RR_EN undefined: fixed priority with channel 0 highest. No pointer register exists.

## Test plan
- NCH=3, ch1 reads 0x0000_0040 alone -> o_sram_val pulses in N; o_req_rdy=3'b010 in N+1 with o_rdat = i_sram_rdat and o_err=0.
- ch0 and ch2 hold SRAM reads continuously, fixed mode -> grants alternate 0,2,0,2 (completing channel excluded); one rdy per cycle.
- ch2 writes 0x1000_0000 with wen=4'hF -> o_iob_val and o_iob_wen=4'hF, o_sram_wen=0. i_iob_rdy in N+3 -> o_req_rdy=3'b100 in N+3. A ch0 request is not issued before N+4.
- TMO_CYC=4, IO read, no i_iob_rdy -> o_req_rdy with o_err=1 and o_rdat=0 in N+4. A late i_iob_rdy in N+6 is ignored.
- MEM_ARB_RR_EN defined, all three channels hold SRAM reads -> grant order 1,2,0,1,… from reset.
- rst asserted while in IOB_WAIT -> all outputs 0 immediately. After release, i_iob_rdy produces no o_req_rdy.
